// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared definitions for the two-port data-memory arbiter:
//               default bus widths, port index constants and the arbiter
//               state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam int c_ADDR_WIDTH = 16;
    localparam int c_DATA_WIDTH = 8;

    // Port 0 is the CPU load/store unit, port 1 the DMA engine.
    localparam int c_PORT_CPU = 0;
    localparam int c_PORT_DMA = 1;

    // LOCKn keeps the memory reserved for port n between the read and the
    // write of an atomic read-modify-write.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin selector.
//               valid[1:0] - pending requests
//               last_grant - index of the requester served most recently
//               grant[1:0] - one-hot grant, zero when nothing is valid
//               Under contention the requester NOT named by last_grant wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        case (valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Arbitrates a CPU port (0) and a DMA port (1) onto a single
//               synchronous-read data memory. One access is granted per cycle,
//               round-robin under contention, with an optional lock that
//               reserves the memory for one port across consecutive accesses.
//
// Ports       : clk, rst_n                 - clock, async active-low reset
//               req_valid/we/lock[1:0]     - per-port request qualifiers
//               req_addr0/1, req_wdata0/1  - per-port address and write data
//               req_ready[1:0]             - one-hot acceptance
//               rsp_valid[1:0], rsp_rdata  - read response, one cycle later
//               mem_write_en, mem_read_en,
//               mem_addr, mem_data_in      - memory command (combinational)
//               mem_data_out               - memory read data
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = c_ADDR_WIDTH,
    parameter int DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_we,
    input  logic [1:0]            req_lock,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [DATA_WIDTH-1:0] req_wdata0,
    input  logic [DATA_WIDTH-1:0] req_wdata1,
    output logic [1:0]            req_ready,

    output logic [1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,

    output logic                  mem_write_en,
    output logic                  mem_read_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_last_grant;
    logic [1:0] r_rsp_pend;

    logic [1:0] w_rr_grant;
    logic [1:0] w_grant;
    logic       w_xfer;
    logic       w_gnt_idx;
    logic       w_gnt_we;
    logic       w_gnt_lock;

    rr_arb2 u_rr_arb2 (
        .valid      (req_valid),
        .last_grant (r_last_grant),
        .grant      (w_rr_grant)
    );

    // Grant selection: round-robin when free, owner-only while locked.
    always_comb begin
        w_grant = 2'b00;
        case (r_state)
            IDLE:    w_grant = w_rr_grant;
            LOCK0:   w_grant = {1'b0, req_valid[c_PORT_CPU]};
            LOCK1:   w_grant = {req_valid[c_PORT_DMA], 1'b0};
            default: w_grant = 2'b00;
        endcase
    end

    // Ready only ever rises alongside valid, so a grant is a transfer.
    assign req_ready  = w_grant;
    assign w_xfer     = |w_grant;
    assign w_gnt_idx  = w_grant[c_PORT_DMA];
    assign w_gnt_we   = req_we[w_gnt_idx];
    assign w_gnt_lock = req_lock[w_gnt_idx];

    // Memory command follows the granted port; everything idles at zero.
    always_comb begin
        mem_write_en = 1'b0;
        mem_read_en  = 1'b0;
        mem_addr     = '0;
        mem_data_in  = '0;
        if (w_xfer) begin
            mem_write_en = w_gnt_we;
            mem_read_en  = ~w_gnt_we;
            mem_addr     = w_gnt_idx ? req_addr1  : req_addr0;
            mem_data_in  = w_gnt_idx ? req_wdata1 : req_wdata0;
        end
    end

    // Any transfer decides the next state from its own lock bit: lock=1
    // enters/stays in the owner's LOCK state, lock=0 frees the memory. In a
    // LOCK state only the owner can transfer, so this covers every case.
    always_comb begin
        w_state_next = r_state;
        if (w_xfer) begin
            if (w_gnt_lock) begin
                w_state_next = w_gnt_idx ? LOCK1 : LOCK0;
            end else begin
                w_state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            r_rsp_pend   <= 2'b00;
        end else begin
            r_state    <= w_state_next;
            r_rsp_pend <= (w_xfer && !w_gnt_we) ? w_grant : 2'b00;
            if (w_xfer) begin
                r_last_grant <= w_gnt_idx;
            end
        end
    end

    // Memory read data arrives the cycle after the read enable is sampled,
    // which is exactly the cycle the pending response is presented.
    assign rsp_valid = r_rsp_pend;
    assign rsp_rdata = (|r_rsp_pend) ? mem_data_out : '0;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter with a behavioural
//               synchronous-read data memory. Memory is preloaded with
//               mem[a] = a[7:0] ^ 8'h5A.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  req_valid;
    logic [1:0]  req_we;
    logic [1:0]  req_lock;
    logic [15:0] req_addr0;
    logic [15:0] req_addr1;
    logic [7:0]  req_wdata0;
    logic [7:0]  req_wdata1;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out;

    logic [7:0]  mem [0:65535];

    int checks;
    int failures;

    dmem_arbiter #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_we       (req_we),
        .req_lock     (req_lock),
        .req_addr0    (req_addr0),
        .req_addr1    (req_addr1),
        .req_wdata0   (req_wdata0),
        .req_wdata1   (req_wdata1),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .mem_write_en (mem_write_en),
        .mem_read_en  (mem_read_en),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural data memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_write_en) mem[mem_addr] <= mem_data_in;
        if (mem_read_en)  mem_data_out  <= mem[mem_addr];
    end

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic [1:0]  lock;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [7:0]  d0;
        logic [7:0]  d1;
        logic [1:0]  e_ready;
        logic        e_we;
        logic        e_re;
        logic [15:0] e_addr;
        logic [7:0]  e_din;
        logic [1:0]  e_rsp;
        logic [7:0]  e_rdata;
    } vec_t;

    localparam int c_NVEC = 27;
    vec_t vecs [0:c_NVEC-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [1:0] l,
                         input logic [15:0] a0, input logic [15:0] a1,
                         input logic [7:0] d0, input logic [7:0] d1);
        req_valid  = v;
        req_we     = w;
        req_lock   = l;
        req_addr0  = a0;
        req_addr1  = a1;
        req_wdata0 = d0;
        req_wdata1 = d1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mem_data_out = 8'h00;
        for (int a = 0; a < 65536; a++) begin
            mem[a] = 8'(a) ^ 8'h5A;
        end

        // valid we lock a0 a1 d0 d1 | ready we re addr din | rsp rdata
        // Write E4 @FF00 on port 0, read back on port 1.
        vecs[0]  = '{2'b00,2'b00,2'b00,16'h0000,16'h0000,8'h00,8'h00, 2'b00,1'b0,1'b0,16'h0000,8'h00, 2'b00,8'h00};
        vecs[1]  = '{2'b01,2'b01,2'b00,16'hFF00,16'h0000,8'hE4,8'h00, 2'b01,1'b1,1'b0,16'hFF00,8'hE4, 2'b00,8'h00};
        vecs[2]  = '{2'b10,2'b00,2'b00,16'h0000,16'hFF00,8'h00,8'h00, 2'b10,1'b0,1'b1,16'hFF00,8'h00, 2'b00,8'h00};
        vecs[3]  = '{2'b00,2'b00,2'b00,16'h0000,16'h0000,8'h00,8'h00, 2'b00,1'b0,1'b0,16'h0000,8'h00, 2'b10,8'hE4};
        // Both ports read every cycle: grants alternate 0,1,0,1,0,1.
        vecs[4]  = '{2'b11,2'b00,2'b00,16'h0020,16'h0030,8'h00,8'h00, 2'b01,1'b0,1'b1,16'h0020,8'h00, 2'b00,8'h00};
        vecs[5]  = '{2'b11,2'b00,2'b00,16'h0020,16'h0030,8'h00,8'h00, 2'b10,1'b0,1'b1,16'h0030,8'h00, 2'b01,8'h7A};
        vecs[6]  = '{2'b11,2'b00,2'b00,16'h0020,16'h0030,8'h00,8'h00, 2'b01,1'b0,1'b1,16'h0020,8'h00, 2'b10,8'h6A};
        vecs[7]  = '{2'b11,2'b00,2'b00,16'h0020,16'h0030,8'h00,8'h00, 2'b10,1'b0,1'b1,16'h0030,8'h00, 2'b01,8'h7A};
        vecs[8]  = '{2'b11,2'b00,2'b00,16'h0020,16'h0030,8'h00,8'h00, 2'b01,1'b0,1'b1,16'h0020,8'h00, 2'b10,8'h6A};
        vecs[9]  = '{2'b11,2'b00,2'b00,16'h0020,16'h0030,8'h00,8'h00, 2'b10,1'b0,1'b1,16'h0030,8'h00, 2'b01,8'h7A};
        vecs[10] = '{2'b00,2'b00,2'b00,16'h0000,16'h0000,8'h00,8'h00, 2'b00,1'b0,1'b0,16'h0000,8'h00, 2'b10,8'h6A};
        // Port 0 alone, four back-to-back reads.
        vecs[11] = '{2'b01,2'b00,2'b00,16'h0000,16'h0000,8'h00,8'h00, 2'b01,1'b0,1'b1,16'h0000,8'h00, 2'b00,8'h00};
        vecs[12] = '{2'b01,2'b00,2'b00,16'h0001,16'h0000,8'h00,8'h00, 2'b01,1'b0,1'b1,16'h0001,8'h00, 2'b01,8'h5A};
        vecs[13] = '{2'b01,2'b00,2'b00,16'h0002,16'h0000,8'h00,8'h00, 2'b01,1'b0,1'b1,16'h0002,8'h00, 2'b01,8'h5B};
        vecs[14] = '{2'b01,2'b00,2'b00,16'h0003,16'h0000,8'h00,8'h00, 2'b01,1'b0,1'b1,16'h0003,8'h00, 2'b01,8'h58};
        vecs[15] = '{2'b00,2'b00,2'b00,16'h0000,16'h0000,8'h00,8'h00, 2'b00,1'b0,1'b0,16'h0000,8'h00, 2'b01,8'h59};
        // Port 1 locked RMW on 0010 while port 0 waits.
        vecs[16] = '{2'b11,2'b00,2'b10,16'h0005,16'h0010,8'h00,8'h00, 2'b10,1'b0,1'b1,16'h0010,8'h00, 2'b00,8'h00};
        vecs[17] = '{2'b01,2'b00,2'b00,16'h0005,16'h0000,8'h00,8'h00, 2'b00,1'b0,1'b0,16'h0000,8'h00, 2'b10,8'h4A};
        vecs[18] = '{2'b11,2'b10,2'b00,16'h0005,16'h0010,8'h00,8'h4B, 2'b10,1'b1,1'b0,16'h0010,8'h4B, 2'b00,8'h00};
        vecs[19] = '{2'b01,2'b00,2'b00,16'h0005,16'h0000,8'h00,8'h00, 2'b01,1'b0,1'b1,16'h0005,8'h00, 2'b00,8'h00};
        vecs[20] = '{2'b00,2'b00,2'b00,16'h0000,16'h0000,8'h00,8'h00, 2'b00,1'b0,1'b0,16'h0000,8'h00, 2'b01,8'h5F};
        // Port 0 lock held across two accesses, port 1 shut out.
        vecs[21] = '{2'b01,2'b01,2'b01,16'h0040,16'h0000,8'h11,8'h00, 2'b01,1'b1,1'b0,16'h0040,8'h11, 2'b00,8'h00};
        vecs[22] = '{2'b11,2'b00,2'b01,16'h0040,16'h0050,8'h00,8'h00, 2'b01,1'b0,1'b1,16'h0040,8'h00, 2'b00,8'h00};
        vecs[23] = '{2'b10,2'b00,2'b00,16'h0000,16'h0050,8'h00,8'h00, 2'b00,1'b0,1'b0,16'h0000,8'h00, 2'b01,8'h11};
        vecs[24] = '{2'b01,2'b00,2'b00,16'h0040,16'h0000,8'h00,8'h00, 2'b01,1'b0,1'b1,16'h0040,8'h00, 2'b00,8'h00};
        vecs[25] = '{2'b10,2'b00,2'b00,16'h0000,16'h0050,8'h00,8'h00, 2'b10,1'b0,1'b1,16'h0050,8'h00, 2'b01,8'h11};
        vecs[26] = '{2'b00,2'b00,2'b00,16'h0000,16'h0000,8'h00,8'h00, 2'b00,1'b0,1'b0,16'h0000,8'h00, 2'b10,8'h0A};

        // Reset state.
        rst_n = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("reset_ready", 32'(req_ready), 32'h0);
        check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        check("reset_rdata", 32'(rsp_rdata), 32'h0);
        check("reset_enables", {30'h0, mem_write_en, mem_read_en}, 32'h0);
        check("reset_addr", 32'(mem_addr), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < c_NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i].valid, vecs[i].we, vecs[i].lock, vecs[i].a0, vecs[i].a1,
                  vecs[i].d0, vecs[i].d1);
            #1;
            check($sformatf("v%0d_ready", i), 32'(req_ready), 32'(vecs[i].e_ready));
            check($sformatf("v%0d_mem_we", i), 32'(mem_write_en), 32'(vecs[i].e_we));
            check($sformatf("v%0d_mem_re", i), 32'(mem_read_en), 32'(vecs[i].e_re));
            check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
            check($sformatf("v%0d_mem_din", i), 32'(mem_data_in), 32'(vecs[i].e_din));
            check($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rsp));
            check($sformatf("v%0d_rsp_rdata", i), 32'(rsp_rdata), 32'(vecs[i].e_rdata));
        end

        // Reset mid-lock with a read in flight.
        @(negedge clk);
        drive(2'b10, 2'b00, 2'b10, 16'h0, 16'h0010, 8'h0, 8'h0);
        #1;
        check("rstlock_accept", 32'(req_ready), 32'h2);
        @(negedge clk);
        drive(2'b01, 2'b00, 2'b00, 16'h0003, 16'h0, 8'h0, 8'h0);
        rst_n = 1'b0;
        #1;
        check("rstlock_rsp_cleared", 32'(rsp_valid), 32'h0);
        check("rstlock_rdata_zero", 32'(rsp_rdata), 32'h0);
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
        rst_n = 1'b1;
        #1;
        check("rstlock_no_rsp_release", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        #1;
        check("rstlock_no_rsp_later", 32'(rsp_valid), 32'h0);
        @(negedge clk);
        drive(2'b11, 2'b00, 2'b00, 16'h0003, 16'h0010, 8'h0, 8'h0);
        #1;
        check("rstlock_first_contention", 32'(req_ready), 32'h1);
        @(negedge clk);
        drive(2'b00, 2'b00, 2'b00, 16'h0, 16'h0, 8'h0, 8'h0);
        #1;
        check("rstlock_rsp_port0", 32'(rsp_valid), 32'h1);
        check("rstlock_rsp_data", 32'(rsp_rdata), 32'h59);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
